// File: rtl/tbus_arbiter_pkg.sv
// Shared types and constants for the two-requester TBUS arbiter.
// Holds the state encoding, operation type codes and the latched request payload.
package tbus_arbiter_pkg;

    localparam int unsigned RESULT_WIDTH  = 64;
    localparam int unsigned TBUS_OPTYPE_W = 1;

    typedef logic [TBUS_OPTYPE_W-1:0] tbus_optype_t;

    localparam tbus_optype_t TBUS_READ  = 1'b0;
    localparam tbus_optype_t TBUS_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tbus_state_e;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0] index;
        logic [63:0]             wdata;
        logic [63:0]             wmask;
        tbus_optype_t            optype;
    } tbus_req_t;

endpackage

// File: rtl/tbus_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and moves to the other requester only when a grant is actually issued.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        grant_o = '0;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = prio_q ? 2'b10 : 2'b01;
                default: grant_o = '0;
            endcase
        end
        prio_d = prio_q;
        if (grant_o[0]) begin
            prio_d = 1'b1;
        end else if (grant_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/tbus_arbiter.sv
// Arbitrates fetch (0) and memblock (1) onto a single TBUS port, one access in flight.
// Flushes abandon the owner's access; a response already in flight is swallowed via drop.
module tbus_arbiter
    import tbus_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NREQ-1:0]                      req_valid,
    output logic [NREQ-1:0]                      req_ready,
    input  logic [NREQ-1:0][RESULT_WIDTH-1:0]    req_index,
    input  logic [NREQ-1:0][63:0]                req_write_data,
    input  logic [NREQ-1:0][63:0]                req_write_mask,
    input  logic [NREQ-1:0][TBUS_OPTYPE_W-1:0]   req_operation_type,
    input  logic [NREQ-1:0]                      req_flush,
    output logic [NREQ-1:0]                      rsp_operation_done,
    output logic [RESULT_WIDTH-1:0]              rsp_read_data,
    output logic                                 tbus_index_valid,
    input  logic                                 tbus_index_ready,
    output logic [63:0]                          tbus_index,
    output logic [63:0]                          tbus_write_data,
    output logic [63:0]                          tbus_write_mask,
    output logic [TBUS_OPTYPE_W-1:0]             tbus_operation_type,
    input  logic [63:0]                          tbus_read_data,
    input  logic                                 tbus_operation_done
);

    tbus_state_e state_q, state_d;
    logic        owner_q, owner_d;
    logic        drop_q,  drop_d;
    tbus_req_t   pay_q,   pay_d;

    logic [NREQ-1:0] eligible;
    logic [1:0]      grant;
    logic            flush_owner;
    logic            in_issue;

    assign eligible    = req_valid & ~req_flush;
    assign flush_owner = req_flush[owner_q];
    assign in_issue    = (state_q == ST_ISSUE);

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (state_q == ST_IDLE),
        .req_i   (eligible),
        .grant_o (grant)
    );

    always_comb begin
        state_d            = state_q;
        owner_d            = owner_q;
        drop_d             = drop_q;
        pay_d              = pay_q;
        rsp_operation_done = '0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d      = grant[1];
                    pay_d.index  = req_index[grant[1]];
                    pay_d.wdata  = req_write_data[grant[1]];
                    pay_d.wmask  = req_write_mask[grant[1]];
                    pay_d.optype = req_operation_type[grant[1]];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Once the handshake fires the access cannot be recalled, only its response dropped.
                if (tbus_index_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = flush_owner;
                end else if (flush_owner) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush_owner) begin
                    drop_d = 1'b1;
                end
                if (tbus_operation_done) begin
                    rsp_operation_done[owner_q] = ~drop_q & ~flush_owner;
                    state_d                     = ST_IDLE;
                    drop_d                      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            drop_q       <= 1'b0;
            pay_q.index  <= '0;
            pay_q.wdata  <= '0;
            pay_q.wmask  <= '0;
            pay_q.optype <= TBUS_READ;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            drop_q  <= drop_d;
            pay_q   <= pay_d;
        end
    end

    // Combinational paths are forced low while reset is held so every output reads 0.
    assign req_ready           = grant & {NREQ{reset_n}};
    assign rsp_read_data       = reset_n ? tbus_read_data : '0;
    assign tbus_index_valid    = in_issue;
    assign tbus_index          = in_issue ? pay_q.index  : '0;
    assign tbus_write_data     = in_issue ? pay_q.wdata  : '0;
    assign tbus_write_mask     = in_issue ? pay_q.wmask  : '0;
    assign tbus_operation_type = in_issue ? pay_q.optype : '0;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed self-checking bench for tbus_arbiter: arbitration, stalls, flushes,
// back-to-back stores and reset in the middle of an access.
module tb_tbus_arbiter;
    import tbus_arbiter_pkg::*;

    localparam int unsigned NREQ = 2;

    logic                               clock;
    logic                               reset_n;
    logic [NREQ-1:0]                    req_valid;
    logic [NREQ-1:0]                    req_ready;
    logic [NREQ-1:0][RESULT_WIDTH-1:0]  req_index;
    logic [NREQ-1:0][63:0]              req_write_data;
    logic [NREQ-1:0][63:0]              req_write_mask;
    logic [NREQ-1:0][TBUS_OPTYPE_W-1:0] req_operation_type;
    logic [NREQ-1:0]                    req_flush;
    logic [NREQ-1:0]                    rsp_operation_done;
    logic [RESULT_WIDTH-1:0]            rsp_read_data;
    logic                               tbus_index_valid;
    logic                               tbus_index_ready;
    logic [63:0]                        tbus_index;
    logic [63:0]                        tbus_write_data;
    logic [63:0]                        tbus_write_mask;
    logic [TBUS_OPTYPE_W-1:0]           tbus_operation_type;
    logic [63:0]                        tbus_read_data;
    logic                               tbus_operation_done;

    int errors = 0;
    int checks = 0;

    tbus_arbiter #(.NREQ(NREQ)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_index           (req_index),
        .req_write_data      (req_write_data),
        .req_write_mask      (req_write_mask),
        .req_operation_type  (req_operation_type),
        .req_flush           (req_flush),
        .rsp_operation_done  (rsp_operation_done),
        .rsp_read_data       (rsp_read_data),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_operation_type (tbus_operation_type),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int unsigned i, input logic [63:0] idx, input logic [63:0] wd,
                           input logic [63:0] wm, input tbus_optype_t op);
        req_index[i]          = idx;
        req_write_data[i]     = wd;
        req_write_mask[i]     = wm;
        req_operation_type[i] = op;
    endtask

    task automatic clear_inputs();
        req_valid           = '0;
        req_index           = '0;
        req_write_data      = '0;
        req_write_mask      = '0;
        req_operation_type  = '0;
        req_flush           = '0;
        tbus_index_ready    = 1'b0;
        tbus_read_data      = '0;
        tbus_operation_done = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n             = 1'b0;
        req_valid           = 2'b11;
        tbus_read_data      = 64'h1234;
        tbus_operation_done = 1'b1;
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", tbus_index_valid); end
        checks++; if (tbus_index !== 64'h0) begin errors++; $display("FAIL reset_index got=%h exp=0", tbus_index); end
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL reset_rsp got=%b exp=00", rsp_operation_done); end
        checks++; if (rsp_read_data !== 64'h0) begin errors++; $display("FAIL reset_read_data got=%h exp=0", rsp_read_data); end
        step();
        step();
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid got=%b exp=0", tbus_index_valid); end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_contention();
        set_req(0, 64'h1000, 64'h0, 64'h0, TBUS_READ);
        set_req(1, 64'h2000, 64'h0, 64'h0, TBUS_READ);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL cont_first_grant got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b10;
        #1;
        checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL cont_issue_valid got=%b exp=1", tbus_index_valid); end
        checks++; if (tbus_index !== 64'h1000) begin errors++; $display("FAIL cont_issue_index0 got=%h exp=1000", tbus_index); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL cont_no_ready_in_issue got=%b exp=00", req_ready); end
        tbus_index_ready = 1'b1;
        step();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'h55;
        #1;
        checks++; if (rsp_operation_done !== 2'b01) begin errors++; $display("FAIL cont_rsp0 got=%b exp=01", rsp_operation_done); end
        checks++; if (rsp_read_data !== 64'h55) begin errors++; $display("FAIL cont_read_data got=%h exp=55", rsp_read_data); end
        step();
        tbus_operation_done = 1'b0;
        req_valid           = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL cont_second_grant got=%b exp=10", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (tbus_index !== 64'h2000) begin errors++; $display("FAIL cont_issue_index1 got=%h exp=2000", tbus_index); end
        tbus_index_ready = 1'b1;
        step();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (rsp_operation_done !== 2'b10) begin errors++; $display("FAIL cont_rsp1 got=%b exp=10", rsp_operation_done); end
        step();
        clear_inputs();
    endtask

    task automatic test_stall();
        set_req(1, 64'h8000_1000, 64'h0, 64'h0, TBUS_READ);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_grant got=%b exp=10", req_ready); end
        step();
        req_valid           = 2'b00;
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got=%b exp=1", i, tbus_index_valid); end
            checks++; if (tbus_index !== 64'h8000_1000) begin errors++; $display("FAIL stall_index_%0d got=%h exp=80001000", i, tbus_index); end
            checks++; if (tbus_operation_type !== TBUS_READ) begin errors++; $display("FAIL stall_optype_%0d got=%b exp=%b", i, tbus_operation_type, TBUS_READ); end
            checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL stall_done_ignored_%0d got=%b exp=00", i, rsp_operation_done); end
            step();
        end
        tbus_operation_done = 1'b0;
        tbus_index_ready    = 1'b1;
        #1;
        checks++; if (tbus_index !== 64'h8000_1000) begin errors++; $display("FAIL stall_index_hs got=%h exp=80001000", tbus_index); end
        step();
        tbus_index_ready = 1'b0;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL stall_wait_valid got=%b exp=0", tbus_index_valid); end
        checks++; if (tbus_index !== 64'h0) begin errors++; $display("FAIL stall_wait_index_zero got=%h exp=0", tbus_index); end
        tbus_operation_done = 1'b1;
        tbus_read_data      = 64'hDEAD;
        #1;
        checks++; if (rsp_operation_done !== 2'b10) begin errors++; $display("FAIL stall_rsp got=%b exp=10", rsp_operation_done); end
        checks++; if (rsp_read_data !== 64'hDEAD) begin errors++; $display("FAIL stall_read_data got=%h exp=dead", rsp_read_data); end
        step();
        clear_inputs();
    endtask

    task automatic test_flush_wait();
        set_req(1, 64'h3000, 64'h0, 64'h0, TBUS_READ);
        set_req(0, 64'h3100, 64'h0, 64'h0, TBUS_READ);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL fw_grant1 got=%b exp=10", req_ready); end
        step();
        req_valid        = 2'b00;
        tbus_index_ready = 1'b1;
        step();
        tbus_index_ready = 1'b0;
        req_flush        = 2'b10;
        step();
        req_flush           = 2'b00;
        req_valid           = 2'b01;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL fw_rsp_dropped got=%b exp=00", rsp_operation_done); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fw_no_grant_in_wait got=%b exp=00", req_ready); end
        step();
        tbus_operation_done = 1'b0;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fw_next_grant0 got=%b exp=01", req_ready); end
        step();
        req_valid        = 2'b00;
        tbus_index_ready = 1'b1;
        step();
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (rsp_operation_done !== 2'b01) begin errors++; $display("FAIL fw_drop_cleared got=%b exp=01", rsp_operation_done); end
        step();
        clear_inputs();
    endtask

    task automatic test_flush_issue();
        set_req(0, 64'h4000, 64'h11, 64'hFF, TBUS_WRITE);
        req_valid = 2'b01;
        step();
        req_valid        = 2'b00;
        req_flush        = 2'b01;
        tbus_index_ready = 1'b0;
        #1;
        checks++; if (tbus_index_valid !== 1'b1) begin errors++; $display("FAIL fi_valid_before_drop got=%b exp=1", tbus_index_valid); end
        step();
        req_flush = 2'b00;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL fi_valid_dropped got=%b exp=0", tbus_index_valid); end
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL fi_no_rsp got=%b exp=00", rsp_operation_done); end
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fi_idle_regrant got=%b exp=01", req_ready); end
        step();
        req_valid        = 2'b00;
        req_flush        = 2'b01;
        tbus_index_ready = 1'b1;
        step();
        req_flush           = 2'b00;
        tbus_index_ready    = 1'b0;
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL fi_wait_valid got=%b exp=0", tbus_index_valid); end
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL fi_hs_flush_rsp got=%b exp=00", rsp_operation_done); end
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [63:0] idx;
        logic [63:0] wd;
        for (int k = 0; k < 4; k++) begin
            idx = 64'h100 + 64'(8 * k);
            wd  = 64'hA0 + 64'(k);
            set_req(0, idx, wd, 64'hFF, TBUS_WRITE);
            req_valid = 2'b01;
            #1;
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_grant_%0d got=%b exp=01", k, req_ready); end
            step();
            #1;
            checks++; if (tbus_index !== idx) begin errors++; $display("FAIL b2b_index_%0d got=%h exp=%h", k, tbus_index, idx); end
            checks++; if (tbus_write_data !== wd) begin errors++; $display("FAIL b2b_wdata_%0d got=%h exp=%h", k, tbus_write_data, wd); end
            checks++; if (tbus_write_mask !== 64'hFF) begin errors++; $display("FAIL b2b_wmask_%0d got=%h exp=ff", k, tbus_write_mask); end
            checks++; if (tbus_operation_type !== TBUS_WRITE) begin errors++; $display("FAIL b2b_optype_%0d got=%b exp=%b", k, tbus_operation_type, TBUS_WRITE); end
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL b2b_busy_%0d got=%b exp=00", k, req_ready); end
            tbus_index_ready = 1'b1;
            step();
            tbus_index_ready    = 1'b0;
            tbus_operation_done = 1'b1;
            #1;
            checks++; if (rsp_operation_done !== 2'b01) begin errors++; $display("FAIL b2b_rsp_%0d got=%b exp=01", k, rsp_operation_done); end
            step();
            tbus_operation_done = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        set_req(1, 64'h5000, 64'h0, 64'h0, TBUS_READ);
        req_valid = 2'b10;
        step();
        req_valid        = 2'b00;
        tbus_index_ready = 1'b1;
        step();
        tbus_index_ready = 1'b0;
        reset_n          = 1'b0;
        tbus_read_data   = 64'hBEEF;
        #1;
        checks++; if (rsp_read_data !== 64'h0) begin errors++; $display("FAIL rm_read_data got=%h exp=0", rsp_read_data); end
        checks++; if (tbus_index_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", tbus_index_valid); end
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL rm_rsp_in_reset got=%b exp=00", rsp_operation_done); end
        step();
        reset_n = 1'b1;
        step();
        tbus_operation_done = 1'b1;
        #1;
        checks++; if (rsp_operation_done !== 2'b00) begin errors++; $display("FAIL rm_late_done got=%b exp=00", rsp_operation_done); end
        checks++; if (tbus_index !== 64'h0) begin errors++; $display("FAIL rm_index got=%h exp=0", tbus_index); end
        step();
        tbus_operation_done = 1'b0;
        req_valid           = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_idle_ptr_reset got=%b exp=01", req_ready); end
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_stall();
        test_flush_wait();
        test_flush_issue();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
